rv_stage_sequencer: RTL
=======================

Name: rv_stage_sequencer

Overview:
- Multi-cycle control FSM for the single-cycle RISC-V datapath.
- Sequences the datapath enables (pc, pc_adder, instruction memory, decode, register file, immediate, ALU muxes, ALU) through FETCH, DECODE, EXECUTE, WRITEBACK and PC_UPDATE, one stage per cycle.
- Supports run, single-step and halt, with a fetch timeout, an illegal-opcode trap and a retired-instruction counter.
- Sits beside the datapath top; its outputs drive the existing enable and select nets directly.

Parameters:
- CNT_W, 32, width of retired_count.
- FETCH_TIMEOUT, 16, maximum FETCH cycles waiting for mem_ready before a fault; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; continuous execution while high.
- step  input  1  one-cycle pulse; executes exactly one instruction from IDLE.
- halt_req  input  1  level; stop at the next instruction boundary.
- mem_ready  input  1  instruction memory data valid.
- opcode  input  7  instr[6:0] from decode, sampled in DECODE.
- rd  input  5  destination register from decode, sampled in DECODE.
- pc_enable, pc_adder_enable, instr_enable, decode_enable, register_enable, write_enable, immed_enable, alu_mux_enable, alu_enable  output  1 each  datapath stage enables.
- reg_data_select, imm_data_select  output  1 each  ALU operand-B source select (one-hot or both 0).
- state  output  3  current state encoding, for debug.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high in HALT.
- fault  output  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 ECALL/EBREAK.
- retired_count  output  CNT_W  instructions completed.

Behaviour:
- Decided: one clock (clk); asynchronous, active-low reset (rst_n).
- Reset: state=IDLE, all enables and selects 0, fault=00, retired_count=0, timeout counter=0. Reset applies immediately, including mid-instruction; the partial instruction is abandoned and not counted.
- Output timing: all outputs are Moore, decoded from registered state plus latched class bits. They are valid in the cycle the state is held.
- Encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, PC_UPDATE=5, HALT=6. Value 7 is unused and recovers to IDLE.
- IDLE:
  - To FETCH when run=1, or when step=1 (sets a step_mode flag).
  - halt_req=1 in IDLE blocks the start and holds IDLE.
- FETCH:
  - instr_enable=1.
  - mem_ready=1 goes to DECODE; the timeout counter clears.
  - Otherwise the counter increments. After FETCH_TIMEOUT consecutive cycles without mem_ready: go to HALT with fault=10.
- DECODE:
  - decode_enable=1, immed_enable=1, register_enable=1 (read).
  - Latch the class from opcode:
    - R 0110011: reg_sel, wb=1.
    - I-ALU 0010011: imm_sel, wb=1.
    - LOAD 0000011: imm_sel, wb=1.
    - STORE 0100011: imm_sel, wb=0.
    - SYSTEM 1110011: go to HALT, fault=11.
    - Any other value: go to HALT, fault=01.
  - wb is forced to 0 when rd=0.
- EXECUTE:
  - alu_mux_enable=1, alu_enable=1, with the latched operand select driven.
  - To WRITEBACK if wb=1, else to PC_UPDATE.
- WRITEBACK: register_enable=1, write_enable=1; to PC_UPDATE. write_enable is never high in any other state.
- PC_UPDATE:
  - pc_adder_enable=1, pc_enable=1.
  - retired_count increments, wrapping modulo 2^CNT_W.
  - Next state: FETCH if run=1, halt_req=0 and step_mode=0. Otherwise IDLE, clearing step_mode.
- Simultaneous events:
  - halt_req wins over run at PC_UPDATE.
  - step is ignored outside IDLE.
  - run and step together in IDLE: run-mode (step_mode=0).
- HALT: all enables 0, halted=1. Exited only by rst_n.
- Latency: 5 cycles per instruction with writeback, 4 without, plus one cycle per extra FETCH wait.

Decomposition:
- Shared package rv_ctrl_pkg:
  - state enum.
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_SYSTEM.
  - fault codes.
- One natural sub-module, rv_opcode_classifier: combinational opcode and rd in; valid, wb, imm_sel, is_system out.
- The FSM, timeout counter and retired counter stay in the top.

Test Plan:
- Reset release, run=1, mem_ready=1, opcode=0110011, rd=5: state sequence 1,2,3,4,5,1; write_enable is high only in state 4; reg_data_select=1; retired_count=1 after the first PC_UPDATE.
- step pulse in IDLE with opcode=0100011: states 1,2,3,5,0; no write_enable; imm_data_select=1; retired_count=1; stays IDLE with run=0.
- opcode=0010011, rd=0: WRITEBACK skipped; 4-cycle instruction.
- mem_ready held 0 with FETCH_TIMEOUT=16: HALT entered after 16 FETCH cycles; fault=10; halted=1; further run has no effect.
- opcode=1111111: HALT from DECODE, fault=01, retired_count unchanged. Repeat with opcode=1110011: fault=11.
- halt_req raised during EXECUTE while run=1: instruction completes, retired increments, then IDLE. rst_n pulsed low during WRITEBACK: outputs clear immediately and asynchronously, count=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RISC-V multi-cycle stage sequencer.
//   state_e      : FSM state encoding (also exported on the debug port)
//   OP_*         : major opcode values recognised by the classifier
//   FLT_*        : fault codes reported on the fault port
//   ctrl_out_t   : bundle of all Moore outputs driven toward the datapath
//   ctrl_decode(): maps a state plus the latched operand select to outputs
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_PC_UPDATE = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;
  localparam logic [1:0] FLT_SYSTEM  = 2'b11;

  typedef struct packed {
    logic pc_enable;
    logic pc_adder_enable;
    logic instr_enable;
    logic decode_enable;
    logic register_enable;
    logic write_enable;
    logic immed_enable;
    logic alu_mux_enable;
    logic alu_enable;
    logic reg_data_select;
    logic imm_data_select;
    logic busy;
    logic halted;
  } ctrl_out_t;

  // Output image of a state. Operand selects are only driven while the ALU
  // is actually consuming them; outside EXECUTE both stay low.
  function automatic ctrl_out_t ctrl_decode(input state_e st, input logic imm_sel);
    ctrl_out_t o;
    o = '0;
    case (st)
      ST_FETCH: begin
        o.instr_enable = 1'b1;
        o.busy         = 1'b1;
      end
      ST_DECODE: begin
        o.decode_enable   = 1'b1;
        o.immed_enable    = 1'b1;
        o.register_enable = 1'b1;
        o.busy            = 1'b1;
      end
      ST_EXECUTE: begin
        o.alu_mux_enable  = 1'b1;
        o.alu_enable      = 1'b1;
        o.imm_data_select = imm_sel;
        o.reg_data_select = ~imm_sel;
        o.busy            = 1'b1;
      end
      ST_WRITEBACK: begin
        o.register_enable = 1'b1;
        o.write_enable    = 1'b1;
        o.busy            = 1'b1;
      end
      ST_PC_UPDATE: begin
        o.pc_adder_enable = 1'b1;
        o.pc_enable       = 1'b1;
        o.busy            = 1'b1;
      end
      ST_HALT:  o.halted = 1'b1;
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rv_opcode_classifier.sv
// Combinational opcode classifier.
//   opcode    : instr[6:0]
//   rd        : destination register index
//   valid     : opcode is one of the supported classes (SYSTEM included)
//   wb        : instruction writes the register file (suppressed for x0)
//   imm_sel   : ALU operand B comes from the immediate
//   is_system : ECALL/EBREAK class, which traps to HALT
module rv_opcode_classifier
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  output logic       valid,
  output logic       wb,
  output logic       imm_sel,
  output logic       is_system
);

  logic wb_raw;

  always_comb begin
    valid     = 1'b0;
    wb_raw    = 1'b0;
    imm_sel   = 1'b0;
    is_system = 1'b0;
    case (opcode)
      OP_R:      begin valid = 1'b1; wb_raw = 1'b1; end
      OP_IMM:    begin valid = 1'b1; wb_raw = 1'b1; imm_sel = 1'b1; end
      OP_LOAD:   begin valid = 1'b1; wb_raw = 1'b1; imm_sel = 1'b1; end
      OP_STORE:  begin valid = 1'b1; imm_sel = 1'b1; end
      OP_SYSTEM: begin valid = 1'b1; is_system = 1'b1; end
      default:   valid = 1'b0;
    endcase
  end

  // Writes to x0 are architecturally discarded, so skip WRITEBACK entirely.
  assign wb = wb_raw & (rd != 5'd0);

endmodule

// File: rtl/rv_stage_sequencer.sv
// Multi-cycle control FSM for the single-cycle RISC-V datapath.
// Walks FETCH -> DECODE -> EXECUTE -> [WRITEBACK] -> PC_UPDATE, one stage per
// cycle, with run / single-step / halt control, a fetch timeout, an illegal
// opcode trap and a retired-instruction counter.
//   clk, rst_n         : clock, asynchronous active-low reset
//   run, step, halt_req: execution control (level, pulse, level)
//   mem_ready          : instruction memory data valid
//   opcode, rd         : decoded instruction fields, sampled in DECODE
//   *_enable           : datapath stage enables
//   reg/imm_data_select: ALU operand-B source select
//   state, busy, halted: debug / status
//   fault              : 00 none, 01 illegal, 10 fetch timeout, 11 system
//   retired_count      : completed instructions, wraps
// All outputs are registered images of the state being entered, so they are
// valid for the whole cycle that state is held.
module rv_stage_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             mem_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  output logic             pc_enable,
  output logic             pc_adder_enable,
  output logic             instr_enable,
  output logic             decode_enable,
  output logic             register_enable,
  output logic             write_enable,
  output logic             immed_enable,
  output logic             alu_mux_enable,
  output logic             alu_enable,
  output logic             reg_data_select,
  output logic             imm_data_select,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired_count
);

  // Last counter value before the timeout fires: FETCH is held exactly
  // FETCH_TIMEOUT cycles without mem_ready before HALT.
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e           state_q, state_n;
  logic             step_mode_q, step_mode_n;
  logic             wb_q, wb_n;
  logic             imm_q, imm_n;
  logic [1:0]       fault_q, fault_n;
  logic [7:0]       tmo_q, tmo_n;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  ctrl_out_t        out_q;

  logic cls_valid, cls_wb, cls_imm, cls_sys;

  rv_opcode_classifier u_cls (
    .opcode    (opcode),
    .rd        (rd),
    .valid     (cls_valid),
    .wb        (cls_wb),
    .imm_sel   (cls_imm),
    .is_system (cls_sys)
  );

  always_comb begin
    state_n     = state_q;
    step_mode_n = step_mode_q;
    wb_n        = wb_q;
    imm_n       = imm_q;
    fault_n     = fault_q;
    tmo_n       = tmo_q;
    retire      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_n = '0;
        // halt_req blocks a start; run beats step when both are present.
        if (!halt_req && (run || step)) begin
          state_n     = ST_FETCH;
          step_mode_n = ~run;
        end
      end
      ST_FETCH: begin
        if (mem_ready) begin
          state_n = ST_DECODE;
          tmo_n   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_n = ST_HALT;
          fault_n = FLT_TIMEOUT;
          tmo_n   = '0;
        end else begin
          tmo_n = tmo_q + 8'd1;
        end
      end
      ST_DECODE: begin
        if (!cls_valid) begin
          state_n = ST_HALT;
          fault_n = FLT_ILLEGAL;
        end else if (cls_sys) begin
          state_n = ST_HALT;
          fault_n = FLT_SYSTEM;
        end else begin
          state_n = ST_EXECUTE;
          wb_n    = cls_wb;
          imm_n   = cls_imm;
        end
      end
      ST_EXECUTE:   state_n = wb_q ? ST_WRITEBACK : ST_PC_UPDATE;
      ST_WRITEBACK: state_n = ST_PC_UPDATE;
      ST_PC_UPDATE: begin
        retire = 1'b1;
        if (run && !halt_req && !step_mode_q) begin
          state_n = ST_FETCH;
        end else begin
          state_n     = ST_IDLE;
          step_mode_n = 1'b0;
        end
      end
      ST_HALT: state_n = ST_HALT;
      // Unused encoding: fall back to IDLE.
      default: begin
        state_n     = ST_IDLE;
        step_mode_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_mode_q <= 1'b0;
      wb_q        <= 1'b0;
      imm_q       <= 1'b0;
      fault_q     <= FLT_NONE;
      tmo_q       <= '0;
      retired_q   <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_n;
      step_mode_q <= step_mode_n;
      wb_q        <= wb_n;
      imm_q       <= imm_n;
      fault_q     <= fault_n;
      tmo_q       <= tmo_n;
      if (retire) retired_q <= retired_q + 1'b1;
      // Registered Moore outputs: decode the state being entered.
      out_q       <= ctrl_decode(state_n, imm_n);
    end
  end

  assign pc_enable       = out_q.pc_enable;
  assign pc_adder_enable = out_q.pc_adder_enable;
  assign instr_enable    = out_q.instr_enable;
  assign decode_enable   = out_q.decode_enable;
  assign register_enable = out_q.register_enable;
  assign write_enable    = out_q.write_enable;
  assign immed_enable    = out_q.immed_enable;
  assign alu_mux_enable  = out_q.alu_mux_enable;
  assign alu_enable      = out_q.alu_enable;
  assign reg_data_select = out_q.reg_data_select;
  assign imm_data_select = out_q.imm_data_select;
  assign busy            = out_q.busy;
  assign halted          = out_q.halted;
  assign state           = state_q;
  assign fault           = fault_q;
  assign retired_count   = retired_q;

endmodule
